fpadd_scheduler: RTL



---
 rtl/fpadd_sched_pkg.sv | 50 +++++
 rtl/fpadd_sched_rr_arbiter.sv | 44 ++++
 rtl/fpadd_scheduler.sv | 138 +++++++++++++
 3 files changed

// File: rtl/fpadd_sched_pkg.sv
// Shared types, FP32 field constants and operand classification for fpadd_scheduler.
package fpadd_sched_pkg;

  typedef enum logic [2:0] {
    IDLE, LOAD, ALIGN, ADD, NORM, ROUND, RESP
  } state_t;

  typedef enum logic [1:0] {
    ZERO, NORMAL, INF, NAN
  } op_class_t;

  localparam int SIGN_W = 1;
  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;
  localparam int FP_W   = SIGN_W + EXP_W + MANT_W;

  localparam logic [FP_W-1:0]  QNAN    = 32'h7FC00000;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  // Denormals (exp == 0) fold into ZERO.
  function automatic op_class_t classify(input logic [FP_W-1:0] x);
    op_class_t c;
    c = NORMAL;
    if (x[MANT_W +: EXP_W] == '0)
      c = ZERO;
    else if (x[MANT_W +: EXP_W] == EXP_MAX)
      c = (x[MANT_W-1:0] == '0) ? INF : NAN;
    return c;
  endfunction

  function automatic logic [FP_W-1:0] bypass_result(input logic [FP_W-1:0] a,
                                                    input logic [FP_W-1:0] b);
    op_class_t ca, cb;
    logic sa, sb;
    logic [FP_W-1:0] r;
    ca = classify(a);
    cb = classify(b);
    sa = a[EXP_W+MANT_W];
    sb = b[EXP_W+MANT_W];
    r  = a;
    if (ca == NAN || cb == NAN)        r = QNAN;
    else if (ca == INF && cb == INF)   r = (sa != sb) ? QNAN : a;
    else if (ca == INF)                r = a;
    else if (cb == INF)                r = b;
    else if (ca == ZERO && cb == ZERO) r = (sa && sb) ? 32'h80000000 : 32'h00000000;
    else if (ca == ZERO)               r = b;
    return r;
  endfunction

endpackage

// File: rtl/fpadd_sched_rr_arbiter.sv
// Round-robin grant over req_valid, searching upward from ptr+1 with wrap.
module fpadd_sched_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int ID_W = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req_valid,
  input  logic            accept,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] grant_idx,
  output logic            found
);

  logic [ID_W-1:0] ptr;
  int              best_d;
  int              d;

  // Distance from ptr+1 (mod NREQ); smallest distance among valid requesters wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    best_d    = NREQ;
    d         = 0;
    for (int i = 0; i < NREQ; i++) begin
      d = i - int'(ptr) - 1;
      if (d < 0) d = d + NREQ;
      if (req_valid[i] && d < best_d) begin
        best_d    = d;
        grant_idx = ID_W'(i);
        found     = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++)
      grant[i] = found && (grant_idx == ID_W'(i));
  end

  always_ff @(posedge clk) begin
    if (reset)       ptr <= ID_W'(NREQ - 1);
    else if (accept) ptr <= grant_idx;
  end

endmodule

// File: rtl/fpadd_scheduler.sv
// Shares one multi-cycle FP32 adder datapath between NREQ requesters with tagged responses.
// FPADD_SCHED_BYPASS_EN: special operands (zero/inf/nan) skip the datapath, LOAD -> RESP.
module fpadd_scheduler
  import fpadd_sched_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [31:0]        resp_result,
  output logic [ID_W-1:0]    resp_id,
  output logic [31:0]        dp_opA,
  output logic [31:0]        dp_opB,
  output logic               dp_load,
  output logic               dp_align_en,
  output logic               dp_add_en,
  output logic               dp_norm_en,
  output logic               dp_round_en,
  input  logic [31:0]        dp_result,
  input  logic               dp_round_ovf,
  output state_t             dbg_state
);

  state_t          state, next_state;
  logic [NREQ-1:0] grant;
  logic [ID_W-1:0] grant_idx;
  logic            grant_found;
  logic            accept;
  logic            renorm;
  logic [31:0]     sel_a, sel_b;

  fpadd_sched_rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .accept    (accept),
    .grant     (grant),
    .grant_idx (grant_idx),
    .found     (grant_found)
  );

  assign req_ready  = (state == IDLE) ? grant : '0;
  assign accept     = (state == IDLE) && grant_found;
  assign resp_valid = (state == RESP);
  assign dbg_state  = state;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_a = req_a[32*i +: 32];
        sel_b = req_b[32*i +: 32];
      end
    end
  end

`ifdef FPADD_SCHED_BYPASS_EN
  logic        byp_hit;
  logic [31:0] byp_res;

  always_ff @(posedge clk) begin
    if (reset) begin
      byp_hit <= 1'b0;
      byp_res <= '0;
    end else if (accept) begin
      byp_hit <= (classify(sel_a) != NORMAL) || (classify(sel_b) != NORMAL);
      byp_res <= bypass_result(sel_a, sel_b);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state  = state;
    dp_load     = 1'b0;
    dp_align_en = 1'b0;
    dp_add_en   = 1'b0;
    dp_norm_en  = 1'b0;
    dp_round_en = 1'b0;
    case (state)
      IDLE:  if (accept) next_state = LOAD;
      LOAD: begin
        dp_load    = 1'b1;
        next_state = ALIGN;
`ifdef FPADD_SCHED_BYPASS_EN
        if (byp_hit) next_state = RESP;
`endif
      end
      ALIGN: begin dp_align_en = 1'b1; next_state = ADD;   end
      ADD:   begin dp_add_en   = 1'b1; next_state = NORM;  end
      NORM:  begin dp_norm_en  = 1'b1; next_state = ROUND; end
      ROUND: begin
        dp_round_en = 1'b1;
        // Only the first rounding overflow earns a re-normalize pass.
        next_state  = (dp_round_ovf && !renorm) ? NORM : RESP;
      end
      RESP:    if (resp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dp_opA      <= '0;
      dp_opB      <= '0;
      resp_id     <= '0;
      resp_result <= '0;
      renorm      <= 1'b0;
    end else begin
      if (accept) begin
        dp_opA  <= sel_a;
        dp_opB  <= sel_b;
        resp_id <= grant_idx;
        renorm  <= 1'b0;
      end
      if (state == ROUND) begin
        if (dp_round_ovf && !renorm) renorm      <= 1'b1;
        else                         resp_result <= dp_result;
      end
`ifdef FPADD_SCHED_BYPASS_EN
      if (state == LOAD && byp_hit) resp_result <= byp_res;
`endif
    end
  end

endmodule
